ysyx_23060184_lsu_stage: RTL and testbench
==========================================

// Module: ysyx_23060184_lsu_stage
// PURPOSE
//  Memory-access stage directly downstream of the execute stage. Takes the ALU result
//  as the address and the rs2 value as store data. Runs a multi-cycle load/store on a
//  simple request/response data bus. Hands the aligned, extended load data or the ALU
//  result to write-back through a valid/ready handshake. One instruction in flight.
// PARAMETERS
//  DATA_WIDTH  32  address/data width; only 32 is supported (byte lanes = 4)
// PORTS
//  clk         in   1   clock
//  rstn        in   1   reset, synchronous, active-high (1 = reset)
//  Evalid      in   1   execute stage has a valid instruction
//  Mready      out  1   this stage accepts an instruction
//  ALUResult   in   32  effective address / non-memory result
//  WriteData   in   32  store data (rs2, already forwarded)
//  MemRead     in   1   load instruction
//  MemWrite    in   1   store instruction (MemRead&MemWrite never both 1)
//  Funct3      in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  mem_req     out  1   bus request valid
//  mem_gnt     in   1   bus accepts request this cycle
//  mem_we      out  1   1 = store
//  mem_addr    out  32  word-aligned address ({addr[31:2],2'b00})
//  mem_wdata   out  32  lane-replicated store data
//  mem_wstrb   out  4   byte enables
//  mem_rvalid  in   1   response valid (loads and stores)
//  mem_rdata   in   32  read data word
//  Mvalid      out  1   result valid to write-back
//  Wready      in   1   write-back accepts the result
//  ResultM     out  32  load data (extended) or passthrough ALUResult
//  Mfault      out  1   misaligned access (0 when MISALIGN_CHECK_EN is off)
// BEHAVIOUR
//  FSM states: IDLE, REQ, RESP, DONE. Reset: state=IDLE, mem_req=0, Mvalid=0,
//   Mfault=0, ResultM=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
//   Mready=1 only in IDLE.
//  IDLE: on Evalid&Mready, register addr, wdata, Funct3, MemRead, MemWrite.
//   No memory op -> DONE with ResultM=ALUResult (1-cycle latency).
//   Memory op -> REQ.
//  REQ: mem_req=1. Hold addr/we/wdata/wstrb stable until mem_gnt. Move to RESP on the
//   edge where mem_gnt=1. mem_req drops the cycle after the grant.
//  RESP: wait for mem_rvalid. On a load, capture the extended data into ResultM.
//   A store leaves ResultM=addr. Then -> DONE. An rvalid arriving in the grant cycle
//   is ignored (the bus guarantees at least 1 cycle of latency).
//  DONE: Mvalid=1, ResultM/Mfault held stable. On Wready -> IDLE.
//   A new instruction is accepted no earlier than the next cycle (no overlap).
//  Load extract: byte lane=addr[1:0], half lane=addr[1]. B/H sign-extend;
//   BU/HU zero-extend; W passes through.
//  Store: wstrb B=4'b0001<<addr[1:0], H=4'b0011<<{addr[1],1'b0}, W=4'b1111.
//   wdata B={4{wd[7:0]}}, H={2{wd[15:0]}}, W=wd.
//  Latency: load/store = 3 + grant wait + response wait cycles, from accept to Mvalid.
//  Reset asserted in any state: IDLE at the next edge. Any bus transaction is
//   abandoned, and the bus ignores responses after reset.
//  Unsupported Funct3 with MemRead/MemWrite is treated as W.
// CONFIGURATION
//  MISALIGN_CHECK_EN defined: H with addr[0]=1, or W with addr[1:0]!=0, issues no
//   bus request. The FSM goes IDLE->DONE with Mfault=1 and ResultM=addr.
//  Undefined: no check. Mfault is tied to 0. The access proceeds with the lane
//   equations above (H at offset 3 uses lanes 2-3; W ignores addr[1:0]).
// TESTING
//  1 ALU op: Evalid=1, MemRead=MemWrite=0, ALUResult=0x1234 -> Mvalid next cycle,
//    ResultM=0x1234, no mem_req.
//  2 LB: addr=0x8000_0003, rdata=0x80FF_FF7F, gnt+rvalid after 2 cycles
//    -> ResultM=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
//  3 SH: addr=0x8000_0002, WriteData=0xDEAD_BEEF -> mem_wstrb=4'b1100,
//    mem_wdata=0xBEEF_BEEF, mem_addr=0x8000_0000, we=1.
//  4 Backpressure: hold mem_gnt=0 for 5 cycles, then Wready=0 for 3 cycles
//    -> request fields stable, Mvalid and ResultM stable, Mready=0 throughout.
//  5 Reset while in RESP -> next cycle IDLE, Mready=1, mem_req=0, Mvalid=0.
//    A subsequent LW completes normally.
//  6 MISALIGN_CHECK_EN: LW at 0x8000_0001 -> no mem_req, Mvalid with Mfault=1.
//    Without the macro, mem_req issued with wstrb=4'b1111.

Source files
------------

// File: rtl/ysyx_23060184_lsu_stage.sv
// ysyx_23060184_lsu_stage: memory-access stage between execute and write-back.
// Takes one instruction at a time from execute. Runs a single load or store on a
// request/response data bus. Returns the aligned load data, or the ALU result, to
// write-back through a valid/ready handshake.
// Optional feature: define MISALIGN_CHECK_EN to fault misaligned H/W accesses
// instead of issuing them on the bus.
module ysyx_23060184_lsu_stage #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    Evalid,
    output logic                    Mready,
    input  logic [DATA_WIDTH-1:0]   ALUResult,
    input  logic [DATA_WIDTH-1:0]   WriteData,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    input  logic [2:0]              Funct3,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    Mvalid,
    input  logic                    Wready,
    output logic [DATA_WIDTH-1:0]   ResultM,
    output logic                    Mfault
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e                  state_q;
    size_e                   size_q;
    logic                    uns_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [DATA_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [STRB_W-1:0]       mem_wstrb_q;
    logic                    mvalid_q;
    logic [DATA_WIDTH-1:0]   result_q;

    size_e                   size_d;
    logic [STRB_W-1:0]       wstrb_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [DATA_WIDTH-1:0]   load_d;
    logic [7:0]              byte_d;
    logic [15:0]             half_d;
    logic                    mem_op_d;

    assign Mready    = (state_q == IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign Mvalid    = mvalid_q;
    assign ResultM   = result_q;
    assign mem_op_d  = MemRead | MemWrite;

    // Decode access size of the incoming instruction; unsupported encodings act as W
    always_comb begin
        size_d = SZ_W;
        case (Funct3)
            3'b000:  size_d = SZ_B;
            3'b001:  size_d = SZ_H;
            3'b100:  size_d = MemRead ? SZ_B : SZ_W;
            3'b101:  size_d = MemRead ? SZ_H : SZ_W;
            default: size_d = SZ_W;
        endcase
    end

    // Byte enables and lane-replicated store data for the incoming instruction
    always_comb begin
        wstrb_d = {STRB_W{1'b1}};
        wdata_d = WriteData;
        case (size_d)
            SZ_B: begin
                wstrb_d = STRB_W'(1) << ALUResult[1:0];
                wdata_d = {4{WriteData[7:0]}};
            end
            SZ_H: begin
                wstrb_d = STRB_W'(3) << {ALUResult[1], 1'b0};
                wdata_d = {2{WriteData[15:0]}};
            end
            default: begin
                wstrb_d = {STRB_W{1'b1}};
                wdata_d = WriteData;
            end
        endcase
    end

    // Select and extend the addressed lane of the returned read word
    always_comb begin
        byte_d = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
        half_d = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_d = mem_rdata;
        case (size_q)
            SZ_B:    load_d = uns_q ? {24'd0, byte_d} : {{24{byte_d[7]}}, byte_d};
            SZ_H:    load_d = uns_q ? {16'd0, half_d} : {{16{half_d[15]}}, half_d};
            default: load_d = mem_rdata;
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    logic misalign_d;
    logic mfault_q;

    assign Mfault = mfault_q;

    // Flag H at an odd address or W off a word boundary
    always_comb begin
        misalign_d = 1'b0;
        if (mem_op_d) begin
            misalign_d = ((size_d == SZ_H) && ALUResult[0]) ||
                         ((size_d == SZ_W) && (ALUResult[1:0] != 2'b00));
        end
    end

    // Hold the fault flag for the instruction currently in the stage
    always_ff @(posedge clk) begin
        if (rstn) begin
            mfault_q <= 1'b0;
        end else if (state_q == IDLE && Evalid) begin
            mfault_q <= misalign_d;
        end
    end
`else
    assign Mfault = 1'b0;
`endif

    // Stage control: accept, bus request, response wait, hand-off to write-back
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q     <= IDLE;
            size_q      <= SZ_W;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            mvalid_q    <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Evalid) begin
                        addr_q <= ALUResult;
                        size_q <= size_d;
                        uns_q  <= Funct3[2];
                        if (!mem_op_d) begin
                            state_q  <= DONE;
                            mvalid_q <= 1'b1;
                            result_q <= ALUResult;
                        end
`ifdef MISALIGN_CHECK_EN
                        else if (misalign_d) begin
                            state_q  <= DONE;
                            mvalid_q <= 1'b1;
                            result_q <= ALUResult;
                        end
`endif
                        else begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= MemWrite;
                            mem_addr_q  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                            mem_wstrb_q <= wstrb_d;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        state_q  <= DONE;
                        mvalid_q <= 1'b1;
                        result_q <= mem_we_q ? addr_q : load_d;
                    end
                end
                DONE: begin
                    if (Wready) begin
                        state_q  <= IDLE;
                        mvalid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_lsu_stage.sv
// Testbench for ysyx_23060184_lsu_stage: directed cases plus random load/store/ALU
// traffic with random bus and write-back stalls, against a lane-arithmetic model.
module tb_ysyx_23060184_lsu_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        Evalid;
    logic        Mready;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        Mvalid;
    logic        Wready;
    logic [31:0] ResultM;
    logic        Mfault;

    int nvec = 0;
    int nerr = 0;

`ifdef MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    ysyx_23060184_lsu_stage #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .Evalid(Evalid), .Mready(Mready),
        .ALUResult(ALUResult), .WriteData(WriteData), .MemRead(MemRead),
        .MemWrite(MemWrite), .Funct3(Funct3), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .Mvalid(Mvalid), .Wready(Wready), .ResultM(ResultM), .Mfault(Mfault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access size in bytes; anything unsupported is a word
    function automatic int unsigned size_of(input logic [2:0] f3, input logic ld);
        case (f3)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b100:  return ld ? 1 : 4;
            3'b101:  return ld ? 2 : 4;
            default: return 4;
        endcase
    endfunction

    function automatic int unsigned lane_off(input int unsigned sz, input logic [31:0] a);
        if (sz == 1) return a % 4;
        if (sz == 2) return ((a % 4) >= 2) ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int unsigned sz;
        logic [31:0] v;
        logic [31:0] lim;
        sz = size_of(f3, 1'b1);
        if (sz == 4) return rd;
        v   = (rd >> (8 * lane_off(sz, a))) & ((sz == 1) ? 32'hFF : 32'hFFFF);
        lim = (sz == 1) ? 32'd128 : 32'd32768;
        if (!f3[2] && v >= lim) v = v - 2 * lim;
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input int unsigned sz, input logic [31:0] a);
        if (sz == 1) return 4'(1 << lane_off(sz, a));
        if (sz == 2) return 4'(3 << lane_off(sz, a));
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input int unsigned sz, input logic [31:0] wd);
        if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic bit misaligned(input int unsigned sz, input logic [31:0] a);
        return (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
    endfunction

    task automatic chk_req(input logic mw, input logic [31:0] a, input logic [31:0] wdx,
                           input logic [3:0] sx);
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_we", 32'(mem_we), 32'(mw));
        chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(sx));
        if (mw) chk("mem_wdata", mem_wdata, wdx);
        chk("mready_busy", 32'(Mready), 32'd0);
    endtask

    // One instruction: accept, optional bus transaction, write-back with stalls
    task automatic do_op(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int gw, input int rw, input int ww);
        int unsigned sz;
        bit          mem;
        bit          fault;
        int          lat;
        int          explat;
        logic [31:0] res;
        logic [31:0] wdx;
        logic [3:0]  sx;
        sz     = size_of(f3, mr);
        mem    = mr | mw;
        fault  = mem && CHK && misaligned(sz, a);
        wdx    = exp_wdata(sz, wd);
        sx     = exp_strb(sz, a);
        explat = (mem && !fault) ? 3 + gw + rw : 1;
        res    = a;

        @(negedge clk);
        chk("mready_idle", 32'(Mready), 32'd1);
        Evalid = 1'b1; ALUResult = a; WriteData = wd;
        MemRead = mr; MemWrite = mw; Funct3 = f3;
        @(negedge clk);
        lat = 1;
        Evalid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; ALUResult = $urandom;
        if (!mem || fault) begin
            chk("no_req", 32'(mem_req), 32'd0);
        end else begin
            chk_req(mw, a, wdx, sx);
            if (gw == 0) begin
                mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = ~rd;
            end
            for (int g = 0; g < gw; g++) begin
                @(negedge clk);
                lat++;
                chk_req(mw, a, wdx, sx);
                if (g == gw - 1) begin
                    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = ~rd;
                end
            end
            @(negedge clk);
            lat++;
            mem_gnt = 1'b0;
            chk("req_drop", 32'(mem_req), 32'd0);
            chk("mvalid_wait", 32'(Mvalid), 32'd0);
            mem_rvalid = (rw == 0);
            mem_rdata  = rd;
            for (int r = 0; r < rw; r++) begin
                @(negedge clk);
                lat++;
                chk("mvalid_resp", 32'(Mvalid), 32'd0);
                mem_rvalid = (r == rw - 1);
            end
            @(negedge clk);
            lat++;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            res = mw ? a : exp_load(f3, a, rd);
        end
        chk("latency", 32'(lat), 32'(explat));
        chk("mvalid", 32'(Mvalid), 32'd1);
        chk("resultm", ResultM, res);
        chk("mfault", 32'(Mfault), 32'(fault));
        for (int w = 0; w < ww; w++) begin
            @(negedge clk);
            chk("mvalid_hold", 32'(Mvalid), 32'd1);
            chk("resultm_hold", ResultM, res);
            chk("mready_done", 32'(Mready), 32'd0);
        end
        Wready = 1'b1;
        @(negedge clk);
        Wready = 1'b0;
        chk("mvalid_clear", 32'(Mvalid), 32'd0);
    endtask

    initial begin
        rstn = 1'b1; Evalid = 1'b0; ALUResult = '0; WriteData = '0;
        MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; Wready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mready", 32'(Mready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mvalid", 32'(Mvalid), 32'd0);
        chk("rst_mfault", 32'(Mfault), 32'd0);
        chk("rst_resultm", ResultM, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rstn = 1'b0;

        // ALU passthrough
        do_op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0);
        // LB / LBU with two-cycle grant and response waits
        do_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 2, 1, 0);
        do_op(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 2, 1, 0);
        // SH at offset 2
        do_op(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'hDEAD_BEEF, 32'h0, 0, 0, 1);
        // Grant held off 5 cycles, write-back stalled 3 cycles
        do_op(1'b1, 1'b0, 3'b101, 32'h8000_0006, 32'h0, 32'h9ABC_1234, 5, 2, 3);
        // LW at an unaligned address
        do_op(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'hCAFE_F00D, 0, 0, 0);

        // Reset while waiting for the response
        @(negedge clk);
        Evalid = 1'b1; ALUResult = 32'h8000_0010; MemRead = 1'b1; Funct3 = 3'b010;
        @(negedge clk);
        Evalid = 1'b0; MemRead = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("resp_req_low", 32'(mem_req), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        chk("rst_resp_mready", 32'(Mready), 32'd1);
        chk("rst_resp_req", 32'(mem_req), 32'd0);
        chk("rst_resp_mvalid", 32'(Mvalid), 32'd0);
        do_op(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'h1357_9BDF, 1, 1, 1);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 2);
            do_op(kind == 1, kind == 2, 3'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
